// File: rtl/hardfloat_seq_pkg.sv
// Shared definitions for the sequential hardfloat helper blocks.
package hardfloat_seq_pkg;

  // Control sequence for the multi-cycle normalizer: capture, count, shift.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/countLeadingZeros.sv
// Combinational leading-zero counter. An all-zero input reports inWidth.
module countLeadingZeros #(
  parameter int inWidth    = 24,
  parameter int countWidth = 5
) (
  input  logic [inWidth-1:0]    in,
  output logic [countWidth-1:0] count
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    count = countWidth'(inWidth);
    for (int i = 0; i < inWidth; i++) begin
      if (in[i]) count = countWidth'(inWidth - 1 - i);
    end
  end

endmodule

// File: rtl/normalize_sig.sv
// Three-cycle significand normalizer: capture, count leading zeros, then a
// single barrel shift with the exponent clamped at its most negative value.
module normalize_sig
  import hardfloat_seq_pkg::*;
#(
  parameter int sigWidth = 24,
  parameter int expWidth = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [sigWidth-1:0] in_sig,
  input  logic [expWidth-1:0] in_exp,
  output logic [sigWidth-1:0] out_sig,
  output logic [expWidth-1:0] out_exp,
  output logic                out_zero,
  output logic                done
);

  localparam int countWidth = $clog2(sigWidth + 1);

  // Most negative representable exponent, held one bit wider for the subtract.
  localparam logic signed [expWidth:0] EXP_MIN = {2'b11, {(expWidth-1){1'b0}}};

  seq_state_t                  state;
  logic        [sigWidth-1:0]  sig_p0;
  logic signed [expWidth-1:0]  exp_p0;
  logic        [countWidth-1:0] lz_p1;
  logic        [countWidth-1:0] clz_count;

  logic signed [expWidth:0]    exp_ext;
  logic signed [expWidth:0]    exp_diff;
  logic signed [expWidth:0]    exp_sat;
  logic        [expWidth:0]    shamt;
  logic        [sigWidth-1:0]  sig_shifted;

  // Saturate the adjusted exponent at the bottom of the representable range.
  function automatic logic signed [expWidth:0] sat_exp(input logic signed [expWidth:0] e);
    return (e < EXP_MIN) ? EXP_MIN : e;
  endfunction

  // ---- COUNT stage: leading zeros of the captured significand ----
  countLeadingZeros #(
    .inWidth   (sigWidth),
    .countWidth(countWidth)
  ) u_clz (
    .in   (sig_p0),
    .count(clz_count)
  );

  // ---- SHIFT stage: exponent adjust, clamp, and barrel shift ----
  // The shift equals the exponent actually removed, so a clamped result shifts
  // less than lz and can never push a set bit off the top.
  always_comb begin
    exp_ext     = {exp_p0[expWidth-1], exp_p0};
    exp_diff    = exp_ext - $signed({{(expWidth+1-countWidth){1'b0}}, lz_p1});
    exp_sat     = sat_exp(exp_diff);
    shamt       = exp_ext - exp_sat;
    sig_shifted = sig_p0 << shamt;
  end

  // Sequencer with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      out_sig  <= '0;
      out_exp  <= '0;
      out_zero <= 1'b0;
      sig_p0   <= '0;
      exp_p0   <= '0;
      lz_p1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            sig_p0 <= in_sig;
            exp_p0 <= in_exp;
            state  <= COUNT;
          end
        end
        COUNT: begin
          lz_p1 <= clz_count;
          state <= SHIFT;
        end
        SHIFT: begin
          done <= 1'b1;
          if (sig_p0 == '0) begin
            out_zero <= 1'b1;
            out_sig  <= '0;
            out_exp  <= '0;
          end else begin
            out_zero <= 1'b0;
            out_sig  <= sig_shifted;
            out_exp  <= exp_sat[expWidth-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_sig.sv
// Directed and randomized checks of normalize_sig with sigWidth=8, expWidth=6.
module tb_normalize_sig;
  import hardfloat_seq_pkg::*;

  localparam int SW = 8;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [SW-1:0] in_sig;
  logic [EW-1:0] in_exp;
  logic [SW-1:0] out_sig;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic          done;

  normalize_sig #(.sigWidth(SW), .expWidth(EW)) dut (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .in_sig  (in_sig),
    .in_exp  (in_exp),
    .out_sig (out_sig),
    .out_exp (out_exp),
    .out_zero(out_zero),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sig;
    logic [EW-1:0] exp;
    logic          zero;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference: count zeros from the top, subtract, clamp at -2^(EW-1).
  function automatic exp_t model(logic [SW-1:0] s, logic [EW-1:0] e, int due);
    exp_t r;
    int   lz, ei, sh;
    r.due = due;
    if (s == '0) begin
      r.sig  = '0;
      r.exp  = '0;
      r.zero = 1'b1;
    end else begin
      lz = 0;
      while (!s[SW-1-lz]) lz++;
      ei = $signed(e) - lz;
      if (ei < -(2 ** (EW-1))) begin
        sh = $signed(e) + 2 ** (EW-1);
        ei = -(2 ** (EW-1));
      end else begin
        sh = lz;
      end
      r.sig  = s << sh;
      r.exp  = EW'(ei);
      r.zero = 1'b0;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Advance one clock, then score any completion against the queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("done_missing_by_cycle", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.due);
        check("out_sig", out_sig, e.sig);
        check("out_exp", out_exp, e.exp);
        check("out_zero", out_zero, e.zero);
        last = e;
      end
    end
  endtask

  // Present go for one edge; push the expected result if it should be taken.
  task automatic start(logic [SW-1:0] s, logic [EW-1:0] e, bit accepted);
    go = 1'b1;
    in_sig = s;
    in_exp = e;
    step();
    if (accepted) sb.push_back(model(s, e, cyc + 2));
    go = 1'b0;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; in_sig = '0; in_exp = '0;
    last = model('0, '0, 0);
    step(); step();
    check("rst_done", done, 0);
    check("rst_out_sig", out_sig, 0);
    check("rst_out_exp", out_exp, 0);
    check("rst_out_zero", out_zero, 0);
    reset = 1'b0;

    // Basic normalization: 0x10 exp 5 -> 0x80 exp 2
    start(8'h10, 6'd5, 1'b1);
    step(); step();
    check("basic_sig", out_sig, 8'h80);
    check("basic_exp", out_exp, 6'd2);
    step();
    check("done_one_cycle", done, 0);
    check("hold_sig", out_sig, 8'h80);

    // Reset mid-operation aborts without a done pulse
    start(8'h40, 6'd1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_done_e1", done, 0);
    step();
    check("abort_done_e2", done, 0);
    check("abort_sig", out_sig, 0);
    check("abort_exp", out_exp, 0);
    check("abort_zero", out_zero, 0);
    check("abort_state", dut.state, IDLE);
    start(8'h40, 6'd1, 1'b1);
    step(); step();
    check("after_abort_sig", out_sig, 8'h80);

    // Clamped: 0x01 exp -30 -> 0x04 exp -32
    start(8'h01, 6'h22, 1'b1);
    step(); step();
    check("clamp_sig", out_sig, 8'h04);
    check("clamp_exp", out_exp, 6'h20);

    // Zero significand
    start(8'h00, 6'd7, 1'b1);
    step(); step();
    check("zero_flag", out_zero, 1);
    check("zero_sig", out_sig, 0);
    check("zero_exp", out_exp, 0);

    // go while busy is ignored
    start(8'h20, 6'd0, 1'b1);
    start(8'h01, 6'd0, 1'b0);
    step();
    check("busy_sig", out_sig, 8'h80);
    check("busy_exp", out_exp, 6'h3e);
    step();
    check("busy_done_e3", done, 0);
    step(); step(); step();
    check("busy_hold_sig", out_sig, 8'h80);

    // Back-to-back at E and E+3
    start(8'h80, 6'd3, 1'b1);
    step(); step();
    check("b2b_first_sig", out_sig, 8'h80);
    check("b2b_first_exp", out_exp, 6'd3);
    start(8'h03, 6'd0, 1'b1);
    step(); step();
    check("b2b_second_sig", out_sig, 8'hC0);
    check("b2b_second_exp", out_exp, 6'h3a);

    // Boundaries: MSB already set, clamp with zero shift, largest exponent
    start(8'hA5, 6'h20, 1'b1);
    step(); step();
    check("msb_pass_sig", out_sig, 8'hA5);
    check("msb_pass_exp", out_exp, 6'h20);
    start(8'h01, 6'h20, 1'b1);
    step(); step();
    check("clamp_noshift_sig", out_sig, 8'h01);
    start(8'h01, 6'd31, 1'b1);
    step(); step();
    check("max_exp_result", out_exp, 6'd24);

    // Randomized operands scored against the model
    for (int i = 0; i < 12; i++) begin
      start(SW'($urandom), EW'($urandom), 1'b1);
      step(); step();
    end

    // Outputs stay put while idle
    step(); step(); step();
    check("idle_hold_sig", out_sig, last.sig);
    check("idle_hold_exp", out_exp, last.exp);
    check("idle_hold_zero", out_zero, last.zero);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/normalize_sig.md
NORMALIZE_SIG -- requirements
Module: normalize_sig

Interface
REQ-001 SHALL have parameter sigWidth, default 24: significand width in bits.
REQ-002 SHALL have parameter expWidth, default 10: two's-complement exponent width in bits.
REQ-003 SHALL have derived localparam countWidth = $clog2(sigWidth+1): leading-zero count width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port go  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port in_sig  input  sigWidth  unnormalized significand.
REQ-008 SHALL have port in_exp  input  expWidth  signed exponent of in_sig.
REQ-009 SHALL have port out_sig  output  sigWidth  normalized significand, MSB set unless clamped or zero.
REQ-010 SHALL have port out_exp  output  expWidth  signed adjusted exponent.
REQ-011 SHALL have port out_zero  output  1  in_sig was zero.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL use FSM states IDLE, COUNT and SHIFT.
REQ-014 SHALL, at an edge E where go=1 in IDLE, register in_sig and in_exp and enter COUNT.
REQ-015 SHALL, at edge E+1, register the leading-zero count lz of the captured significand and enter SHIFT.
REQ-016 SHALL, at edge E+2, register out_sig, out_exp, out_zero, set done=1 and return to IDLE.
REQ-017 SHALL drive done=1 for exactly one cycle (E+2 to E+3) per accepted go.
REQ-018 SHALL accept the next go at edge E+3 at the earliest (one operation per 3 cycles), including while done=1.
REQ-019 SHALL ignore go in COUNT or SHIFT, with no effect on captured data or the sequence.
REQ-020 SHALL hold out_sig, out_exp and out_zero stable between completions.
REQ-021 SHALL compute the unclamped result as exponent in_exp - lz at width expWidth+1 and significand in_sig << lz.
REQ-022 SHALL clamp when in_exp - lz < -2^(expWidth-1): shift = in_exp + 2^(expWidth-1), out_exp = -2^(expWidth-1).
REQ-023 SHALL, for in_sig = 0, give out_zero=1, out_sig=0, out_exp=0 and still pulse done at E+2.
REQ-024 SHALL, for in_sig with MSB already set, give lz=0 and pass in_sig and in_exp through unchanged.
REQ-025 SHALL, on a clamped result, never shift out a set bit; the shift is at most lz.

Reset
REQ-026 SHALL, while reset=1 at an edge, force state=IDLE, done=0, out_sig=0, out_exp=0, out_zero=0 and clear the captured registers.
REQ-027 SHALL, if reset arrives in COUNT or SHIFT, abort the operation with no done pulse.
REQ-028 SHALL give reset priority over go at the same edge.

Structure
REQ-029 SHALL place the state enum typedef in the shared package hardfloat_seq_pkg.
REQ-030 SHALL instantiate the existing countLeadingZeros primitive (inWidth=sigWidth, countWidth=countWidth) as the sole sub-module for the COUNT stage.
REQ-031 SHALL use a single barrel shift in SHIFT, with no additional sub-modules.

Verification (sigWidth=8, expWidth=6)
REQ-032 SHALL cover: in_sig=8'h10, in_exp=5, go at E -> done at E+2, out_sig=8'h80, out_exp=2, out_zero=0.
REQ-033 SHALL cover: in_sig=8'h01, in_exp=-30 -> out_sig=8'h04, out_exp=-32 (clamped).
REQ-034 SHALL cover: in_sig=8'h00, in_exp=7 -> out_zero=1, out_sig=0, out_exp=0, done at E+2.
REQ-035 SHALL cover: go=1 at E (sig 8'h20) and E+1 (sig 8'h01) -> single done at E+2, out_sig=8'h80; second request ignored.
REQ-036 SHALL cover: reset=1 at E+1 after go at E -> no done at E+2, all outputs 0, state IDLE.
REQ-037 SHALL cover: back-to-back go at E and E+3 with 8'h80/3 then 8'h03/0 -> done at E+2 (8'h80, 3) and E+5 (8'hC0, -6).
